// File: rtl/hpf_decim_out_if.sv
// Valid/ready stream carrying decimated high-pass samples
// from the output FIFO to its consumer.
interface hpf_decim_out_if;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/hpf_decim_out.sv
// IIR output stage: drops warm-up samples, block-averages by DECIM
// with round-half-up, and buffers results in a small FIFO.
module hpf_decim_out #(
  parameter int DECIM      = 4,
  parameter int WARMUP     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic signed [15:0]          filtered_signal,
  hpf_decim_out_if.master             m,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_ovf
);

  localparam int L  = $clog2(DECIM);
  localparam int SW = 16 + L;
  localparam int PW = (L > 0) ? L : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DECIM - 1);
  localparam logic [7:0] WLAST = 8'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic signed [SW-1:0] RND = SW'((2 ** L) / 2);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    S_WARM,
    S_ACC
  } state_t;

  localparam state_t RST_ST = (WARMUP == 0) ? S_ACC : S_WARM;

  state_t state, nstate;
  logic [7:0] wcnt;
  logic [PW-1:0] pcnt;
  logic signed [SW-1:0] acc;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] rsum;
  logic signed [15:0] avg;
  logic wcnt_en, acc_en, last;

  logic signed [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] lvl_nxt;
  logic full, push, pop, wr, ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_ST;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_WARM: if (en && wcnt == WLAST) nstate = S_ACC;
      S_ACC:  nstate = S_ACC;
      default: nstate = RST_ST;
    endcase
  end

  always_comb begin
    wcnt_en = 1'b0;
    acc_en  = 1'b0;
    unique case (state)
      S_WARM: wcnt_en = en;
      S_ACC:  acc_en  = en;
      default: ;
    endcase
  end

  // Block sum never overflows SW bits, so rounding needs no saturation.
  assign last = (pcnt == PLAST);
  assign sum  = acc + SW'(filtered_signal);
  assign rsum = sum + RND;
  assign avg  = 16'(rsum >>> L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      pcnt <= '0;
      acc  <= '0;
    end else begin
      if (wcnt_en) wcnt <= wcnt + 8'd1;
      if (acc_en) begin
        if (last) begin
          pcnt <= '0;
          acc  <= '0;
        end else begin
          pcnt <= pcnt + PW'(1);
          acc  <= sum;
        end
      end
    end
  end

  assign full    = (fifo_level == FULL_LVL);
  assign pop     = m.m_valid & m.m_ready;
  assign push    = acc_en & last;
  assign wr      = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    lvl_nxt = fifo_level;
    unique case (1'b1)
      wr && !pop: lvl_nxt = fifo_level + 1'b1;
      pop && !wr: lvl_nxt = fifo_level - 1'b1;
      default: ;
    endcase
  end

  // Storage needs no reset: an empty FIFO masks m_data to zero.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= avg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      fifo_level <= lvl_nxt;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign m.m_valid = (fifo_level != '0);
  assign m.m_data  = m.m_valid ? mem[rptr] : '0;

endmodule

// File: tb/tb_hpf_decim_out.sv
// Scoreboard bench for hpf_decim_out: directed blocks with
// hand-computed averages, back-pressure, overflow and reset cases.
module tb_hpf_decim_out;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic signed [15:0] fs = '0;
  logic clr_ovf = 1'b0;
  logic [3:0] lvl;
  logic ovf;

  hpf_decim_out_if bus ();

  hpf_decim_out #(
    .DECIM(4),
    .WARMUP(16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .filtered_signal(fs),
    .m(bus),
    .fifo_level(lvl),
    .overflow(ovf),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %0d expected none",
                 bus.m_data);
      end else begin
        chk("m_data", int'(bus.m_data), sb.pop_front());
      end
    end
  end

  task automatic send(input int s, input logic rdy, input logic clr);
    en = 1'b1;
    fs = 16'(s);
    bus.m_ready = rdy;
    clr_ovf = clr;
    @(posedge clk);
    #1;
    en = 1'b0;
    clr_ovf = 1'b0;
    fs = 16'sh5a5a;
  endtask

  task automatic idle(input int n, input logic rdy, input logic clr);
    for (int i = 0; i < n; i++) begin
      en = 1'b0;
      fs = 16'sh7fff;
      bus.m_ready = rdy;
      clr_ovf = clr;
      @(posedge clk);
      #1;
    end
    clr_ovf = 1'b0;
  endtask

  task automatic blk(input int a, input int b, input int c, input int d,
                     input int exp, input logic rdy);
    sb.push_back(exp);
    send(a, rdy, 1'b0);
    send(b, rdy, 1'b0);
    send(c, rdy, 1'b0);
    send(d, rdy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  int pat [16] = '{1,0,1,1, 0,0,1,0, 0,1,1,0, 1,1,0,1};
  int gsmp [12] = '{5,6,7,8, -3,0,3,1, 100,200,300,401};

  initial begin
    bus.m_ready = 1'b0;
    #2;
    chk("rst_valid", int'(bus.m_valid), 0);
    chk("rst_data", int'(bus.m_data), 0);
    chk("rst_level", int'(lvl), 0);
    chk("rst_ovf", int'(ovf), 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Warm-up: 16 discarded, first average after sample 20.
    for (int i = 0; i < 19; i++) send(100, 1'b1, 1'b0);
    chk("warm_valid", int'(bus.m_valid), 0);
    chk("warm_level", int'(lvl), 0);
    sb.push_back(100);
    send(100, 1'b1, 1'b0);
    chk("first_valid", int'(bus.m_valid), 1);
    for (int i = 0; i < 3; i++) send(100, 1'b1, 1'b0);
    chk("gap_valid", int'(bus.m_valid), 0);
    sb.push_back(100);
    send(100, 1'b1, 1'b0);
    chk("second_valid", int'(bus.m_valid), 1);

    // Rounding and extremes.
    blk(1, 2, 2, 2, 2, 1'b1);
    blk(-1, -2, -2, -2, -2, 1'b1);
    blk(1, 1, 2, 2, 2, 1'b1);
    blk(32767, 32767, 32767, 32767, 32767, 1'b1);
    blk(-32768, -32768, -32768, -32768, -32768, 1'b1);
    idle(2, 1'b1, 1'b0);
    chk("drain1_level", int'(lvl), 0);

    // Back-pressure: 8 fit, the 9th is dropped.
    for (int v = 10; v < 18; v++) blk(v, v, v, v, v, 1'b0);
    chk("full_level", int'(lvl), 8);
    chk("full_ovf", int'(ovf), 0);
    for (int i = 0; i < 4; i++) send(18, 1'b0, 1'b0);
    chk("ovf_level", int'(lvl), 8);
    chk("ovf_set", int'(ovf), 1);
    idle(1, 1'b0, 1'b1);
    chk("ovf_clr", int'(ovf), 0);

    // Full FIFO with push and pop on the same edge.
    sb.push_back(19);
    for (int i = 0; i < 3; i++) send(19, 1'b0, 1'b0);
    send(19, 1'b1, 1'b0);
    chk("pp_level", int'(lvl), 8);
    chk("pp_ovf", int'(ovf), 0);
    for (int i = 0; i < 3; i++) send(20, 1'b0, 1'b0);
    send(20, 1'b0, 1'b1);
    chk("set_beats_clr", int'(ovf), 1);
    idle(1, 1'b0, 1'b1);
    chk("ovf_clr2", int'(ovf), 0);
    idle(10, 1'b1, 1'b0);
    chk("empty_valid", int'(bus.m_valid), 0);
    chk("empty_data", int'(bus.m_data), 0);
    chk("empty_level", int'(lvl), 0);

    // Sparse enable with junk on idle cycles.
    sb.push_back(7);
    sb.push_back(0);
    sb.push_back(250);
    begin
      int k;
      k = 0;
      for (int i = 0; k < 12; i++) begin
        if (pat[i % 16] != 0) begin
          send(gsmp[k], 1'b1, 1'b0);
          k++;
        end else begin
          idle(1, 1'b1, 1'b0);
        end
      end
    end
    idle(3, 1'b1, 1'b0);
    chk("gaps_level", int'(lvl), 0);

    // Reset with a partial block and three queued entries.
    for (int v = 40; v < 43; v++)
      for (int i = 0; i < 4; i++) send(v, 1'b0, 1'b0);
    send(77, 1'b0, 1'b0);
    send(77, 1'b0, 1'b0);
    chk("pre_rst_level", int'(lvl), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.m_valid), 0);
    chk("mid_rst_data", int'(bus.m_data), 0);
    chk("mid_rst_level", int'(lvl), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) send(999, 1'b1, 1'b0);
    chk("rewarm_valid", int'(bus.m_valid), 0);
    blk(60, 60, 61, 61, 61, 1'b1);
    chk("rewarm_out", int'(bus.m_valid), 1);
    idle(3, 1'b1, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hpf_decim_out.md
# hpf_decim_out

Output stage directly downstream of the Butterworth high-pass IIR. It takes the filter's 16-bit signed output stream and discards the pipeline warm-up samples. It then decimates by block-averaging with round-half-up and buffers the decimated samples in a small FIFO. The FIFO is exposed through a valid/ready interface to the consumer (DAC formatter, capture logic).

## Interface
Parameters:
- `DECIM`, 4: decimation factor. Power of two, 1..64. `L = log2(DECIM)`.
- `WARMUP`, 16: number of enabled input samples discarded after reset. Range 0..255.
- `FIFO_DEPTH`, 8: FIFO entries. Power of two, 2..64.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: the current `filtered_signal` is a valid sample.
- `filtered_signal`, in, 16: signed sample from the IIR.
- `m_data`, out, 16: signed decimated sample at the FIFO head.
- `m_valid`, out, 1: the FIFO is non-empty.
- `m_ready`, in, 1: consumer accepts `m_data` this cycle.
- `fifo_level`, out, `log2(FIFO_DEPTH)+1`: number of occupied entries.
- `overflow`, out, 1: sticky flag; a decimated sample was dropped.
- `clr_ovf`, in, 1: synchronous clear of `overflow`.

## Operation
- State machine with two states: `WARMUP` and `ACCUM`.
- **`WARMUP`** (entered on reset):
  - Each cycle with `en=1` increments `wcnt` and discards the sample.
  - The FSM moves to `ACCUM` on the edge that accepts the `WARMUP`-th sample.
  - If `WARMUP=0`, reset enters `ACCUM` directly.
- **`ACCUM`**:
  - The accumulator `acc` is signed, `16+L` bits, and cannot overflow.
  - The phase counter `pcnt` runs 0..`DECIM-1`.
  - Each `en` cycle does `acc += sample` and `pcnt++`.
  - When `en=1` and `pcnt==DECIM-1`:
    - `avg = (acc + sample + 2^(L-1)) >>> L` (arithmetic shift). For `DECIM=1`, `avg = sample`.
    - `acc` and `pcnt` reset to 0 and `avg` is pushed.
  - `avg` is always within [-32768, 32767], so no saturation logic is needed.
- Cycles with `en=0` change no counter, accumulator or state.
- **FIFO:**
  - Circular buffer with read and write pointers; `fifo_level` tracks occupancy.
  - `m_data` = entry at the read pointer; it is 0 when empty.
  - Pop occurs when `m_valid && m_ready`.
  - A push when full with no pop drops the new sample, sets `overflow`, and leaves contents and `fifo_level` unchanged.
  - A push and a pop in the same cycle both take effect, even when full. Level is unchanged and no overflow occurs.
  - A pop when empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **`overflow`:** set has priority over `clr_ovf` in the same cycle. Otherwise `clr_ovf=1` clears it.

## Timing
- Reset values:
  - `m_valid=0`, `m_data=0`, `fifo_level=0`, `overflow=0`.
  - State `WARMUP`, `wcnt=0`, `pcnt=0`, `acc=0`.
- **Reset mid-operation:** all FIFO contents and partial accumulation are lost, and warm-up restarts from zero.
- **Latency:** the push happens on the edge that accepts the `DECIM`-th sample of a block. `m_valid` and `m_data` reflect it in the following cycle, i.e. registered with no combinational path from `filtered_signal`.
- **Handshake:**
  - `m_valid` does not depend combinationally on `m_ready`.
  - `m_data` holds stable while `m_valid=1 && m_ready=0`.
  - Back-to-back pops at one per cycle are supported.
- `fifo_level` and `overflow` update on the same edge as the push or pop.
- Throughput: one push per `DECIM` enabled cycles at most; with `DECIM=1`, one per cycle.

## Test plan
1. **Warm-up and first output.** Defaults, `en=1` constant, `filtered_signal=100`, `m_ready=1`. The first 16 samples produce nothing. `m_valid` rises in the cycle after the 20th enabled sample, with `m_data=100`, and repeats every 4 cycles.
2. **Rounding and extremes** (`DECIM=4`, after warm-up):
   - Block 1,2,2,2 gives 2.
   - Block -1,-2,-2,-2 gives -2.
   - Block 1,1,2,2 gives 2.
   - Four samples of 32767 give 32767.
   - Four samples of -32768 give -32768.
3. **Back-pressure and overflow.** With `m_ready=0`, push 9 averages. `fifo_level=8`; the 9th is dropped; `overflow=1`. Pulsing `clr_ovf` gives `overflow=0`. Draining yields the first 8 values in order, then `m_valid=0` and `m_data=0`.
4. **Full with simultaneous push and pop.** With the FIFO at 8, set `m_ready=1` in the push cycle. `fifo_level` stays 8, `overflow` stays 0, and no data is lost. `clr_ovf` in the same cycle as an overflow leaves `overflow=1`.
5. **Enable gaps.** A random `en` pattern (about 50% density) gives outputs identical to the dense-`en` reference model. Counters freeze while `en=0`.
6. **Reset mid-operation.** Assert `rst_n=0` with a partial block and 3 FIFO entries. Outputs go to reset values immediately, without waiting for a clock. After release, 16 samples are discarded again before the first new output.
